// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  // Consecutive data wins tolerated before fetch is forced through.
  localparam int STARVE_LIMIT_DEF = 4;

  // Widest address the payload struct can carry; narrower ports zero-extend.
  localparam int MAX_AW = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic [MAX_AW-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
  } payload_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of back-to-back arbitrations that data won while fetch
// was also waiting; force_fetch raises once the limit is reached.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_valid,
  input  logic both_req,
  input  logic fetch_win,
  output logic force_fetch
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;

  // Next count: clear on any fetch win, bump on a contested data win.
  always_comb begin
    cnt_s = cnt_r;
    if (arb_valid && fetch_win) begin
      cnt_s = {CW{1'b0}};
    end else if (arb_valid && both_req && (cnt_r != LIMIT)) begin
      cnt_s = cnt_r + CW'(1);
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_s;
    end
  end

  assign force_fetch = (cnt_r == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between an instruction-fetch and a data requester.
// One transaction in flight; data has priority except when fetch has been
// passed over STARVE_LIMIT times in a row. A fetch cancelled by i_flush still
// finishes its memory handshake, but its grant/response are hidden.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int AW           = 32
) (
  input  logic          clk,
  input  logic          rst,
  // fetch side
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  input  logic          i_flush,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  // data side
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  // memory port
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  state_e        state_r, state_s;
  owner_e        owner_r, owner_s;
  logic          drop_r, drop_s;
  logic          mem_req_s, mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [31:0]   mem_wdata_s;

  logic          i_req_eff_s;
  logic          any_req_s;
  logic          fetch_win_s;
  logic          force_fetch_s;
  logic          arb_s;
  payload_t      win_s;

  // A fetch request coinciding with a flush is stale and never arbitrates.
  assign i_req_eff_s = i_req & ~i_flush;
  assign any_req_s   = i_req_eff_s | d_req;
  assign fetch_win_s = i_req_eff_s & (~d_req | force_fetch_s);

  mem_arb_starve_ctr #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst        (rst),
    .arb_valid  (arb_s),
    .both_req   (i_req_eff_s & d_req),
    .fetch_win  (fetch_win_s),
    .force_fetch(force_fetch_s)
  );

  // Winner payload; fetches are always reads.
  always_comb begin
    win_s.addr  = fetch_win_s ? MAX_AW'(i_addr) : MAX_AW'(d_addr);
    win_s.we    = fetch_win_s ? 1'b0 : d_we;
    win_s.wdata = fetch_win_s ? 32'h0000_0000 : d_wdata;
  end

  // Next-state, arbitration trigger and handshake strobes.
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    drop_s      = drop_r;
    mem_req_s   = mem_req;
    mem_we_s    = mem_we;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
    arb_s       = 1'b0;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    i_rvalid    = 1'b0;
    d_rvalid    = 1'b0;

    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          arb_s   = 1'b1;
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end

      REQ: begin
        if ((owner_r == OWN_I) && i_flush) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop_r;
        end
        if (mem_ready) begin
          state_s   = RESP;
          mem_req_s = 1'b0;
          if (owner_r == OWN_I) begin
            i_gnt = ~drop_r & ~i_flush;
          end else begin
            d_gnt = 1'b1;
          end
        end else begin
          state_s = REQ;
        end
      end

      RESP: begin
        if (mem_rvalid) begin
          // The response retires any pending drop, flushed or not.
          drop_s = 1'b0;
          if (owner_r == OWN_I) begin
            i_rvalid = ~drop_r & ~i_flush;
          end else begin
            d_rvalid = 1'b1;
          end
          if (any_req_s) begin
            arb_s   = 1'b1;
            state_s = REQ;
          end else begin
            state_s = IDLE;
          end
        end else begin
          if ((owner_r == OWN_I) && i_flush) begin
            drop_s = 1'b1;
          end else begin
            drop_s = drop_r;
          end
          state_s = RESP;
        end
      end

      default: begin
        state_s   = IDLE;
        drop_s    = 1'b0;
        mem_req_s = 1'b0;
      end
    endcase

    if (arb_s) begin
      owner_s     = fetch_win_s ? OWN_I : OWN_D;
      mem_req_s   = 1'b1;
      mem_we_s    = win_s.we;
      mem_addr_s  = win_s.addr[AW-1:0];
      mem_wdata_s = win_s.wdata;
    end else begin
      owner_s = owner_s;
    end
  end

  // Read data is only visible alongside its own strobe.
  always_comb begin
    i_rdata = i_rvalid ? mem_rdata : 32'h0000_0000;
    d_rdata = d_rvalid ? mem_rdata : 32'h0000_0000;
  end

  // State, ownership and registered memory-port request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      owner_r   <= OWN_D;
      drop_r    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      owner_r   <= owner_s;
      drop_r    <= drop_s;
      mem_req   <= mem_req_s;
      mem_we    <= mem_we_s;
      mem_addr  <= mem_addr_s;
      mem_wdata <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change 1 time unit after the
// rising edge, outputs are compared on the falling edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req, i_flush, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec;
  int n_err;

  mem_port_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_flush   (i_flush),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_mem_req"},   {31'h0, mem_req},  32'h0);
    chk_eq({tag, "_mem_we"},    {31'h0, mem_we},   32'h0);
    chk_eq({tag, "_mem_addr"},  mem_addr,          32'h0);
    chk_eq({tag, "_mem_wdata"}, mem_wdata,         32'h0);
    chk_eq({tag, "_gnts"},      {30'h0, i_gnt, d_gnt},       32'h0);
    chk_eq({tag, "_rvalids"},   {30'h0, i_rvalid, d_rvalid}, 32'h0);
    chk_eq({tag, "_i_rdata"},   i_rdata, 32'h0);
    chk_eq({tag, "_d_rdata"},   d_rdata, 32'h0);
  endtask

  // Zero-wait transaction starting in IDLE: request, ack, response.
  task automatic run_txn(input logic is_d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata, input string tag);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    step();
    mem_ready = 1'b1;
    sample();
    chk_eq({tag, "_mem_req"},  {31'h0, mem_req}, 32'h1);
    chk_eq({tag, "_mem_addr"}, mem_addr, addr);
    chk_eq({tag, "_mem_we"},   {31'h0, mem_we}, {31'h0, we});
    if (is_d) chk_eq({tag, "_mem_wdata"}, mem_wdata, wdata);
    chk_eq({tag, "_i_gnt"}, {31'h0, i_gnt}, {31'h0, ~is_d});
    chk_eq({tag, "_d_gnt"}, {31'h0, d_gnt}, {31'h0, is_d});
    step();
    mem_ready = 1'b0; i_req = 1'b0; d_req = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = rdata;
    sample();
    chk_eq({tag, "_i_rvalid"}, {31'h0, i_rvalid}, {31'h0, ~is_d});
    chk_eq({tag, "_d_rvalid"}, {31'h0, d_rvalid}, {31'h0, is_d});
    chk_eq({tag, "_rdata"}, is_d ? d_rdata : i_rdata, rdata);
    chk_eq({tag, "_mem_req_low"}, {31'h0, mem_req}, 32'h0);
    step();
    mem_rvalid = 1'b0;
  endtask

  logic exp_i;

  initial begin
    n_vec = 0;
    n_err = 0;
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    // Response strobe and data present during reset must not leak out.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b1;
    #6;
    chk_all_zero("reset");
    idle_inputs();
    @(negedge clk); #2 rst = 1'b1;
    step();

    // Single fetch with one wait state on the accept.
    i_req = 1'b1; i_addr = 32'h0000_0040;
    sample(); chk_eq("f1_idle_mem_req", {31'h0, mem_req}, 32'h0);
    step();
    sample();
    chk_eq("f1_mem_req", {31'h0, mem_req}, 32'h1);
    chk_eq("f1_mem_addr", mem_addr, 32'h0000_0040);
    chk_eq("f1_mem_we", {31'h0, mem_we}, 32'h0);
    chk_eq("f1_wait_gnt", {31'h0, i_gnt}, 32'h0);
    step();
    mem_ready = 1'b1;
    sample();
    chk_eq("f1_i_gnt", {31'h0, i_gnt}, 32'h1);
    chk_eq("f1_d_gnt", {31'h0, d_gnt}, 32'h0);
    step();
    mem_ready = 1'b0; i_req = 1'b0;
    sample();
    chk_eq("f1_resp_mem_req", {31'h0, mem_req}, 32'h0);
    chk_eq("f1_early_rvalid", {31'h0, i_rvalid}, 32'h0);
    step();
    mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    sample();
    chk_eq("f1_i_rvalid", {31'h0, i_rvalid}, 32'h1);
    chk_eq("f1_i_rdata", i_rdata, 32'h0050_0093);
    chk_eq("f1_d_rvalid", {31'h0, d_rvalid}, 32'h0);
    chk_eq("f1_d_rdata", d_rdata, 32'h0);
    step();
    mem_rvalid = 1'b0;
    sample();
    chk_eq("f1_rvalid_once", {31'h0, i_rvalid}, 32'h0);
    chk_eq("f1_rdata_zero", i_rdata, 32'h0);
    step();

    // Store.
    run_txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h5A5A_0001, "store");

    // Flush during RESP of a fetch, then a data request goes straight through.
    i_req = 1'b1; i_addr = 32'h0000_0080;
    step();
    mem_ready = 1'b1;
    sample();
    chk_eq("fl_mem_addr", mem_addr, 32'h0000_0080);
    chk_eq("fl_i_gnt", {31'h0, i_gnt}, 32'h1);
    step();
    mem_ready = 1'b0; i_req = 1'b0; i_flush = 1'b1;
    d_req = 1'b1; d_addr = 32'h0000_0200; d_we = 1'b0;
    sample();
    chk_eq("fl_resp_d_gnt", {31'h0, d_gnt}, 32'h0);
    step();
    i_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    sample();
    chk_eq("fl_i_rvalid", {31'h0, i_rvalid}, 32'h0);
    chk_eq("fl_i_rdata", i_rdata, 32'h0);
    chk_eq("fl_d_rvalid", {31'h0, d_rvalid}, 32'h0);
    step();
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    sample();
    chk_eq("b2b_mem_req", {31'h0, mem_req}, 32'h1);
    chk_eq("b2b_mem_addr", mem_addr, 32'h0000_0200);
    chk_eq("b2b_d_gnt", {31'h0, d_gnt}, 32'h1);
    step();
    mem_ready = 1'b0; d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    sample();
    chk_eq("b2b_d_rvalid", {31'h0, d_rvalid}, 32'h1);
    chk_eq("b2b_d_rdata", d_rdata, 32'hCAFE_F00D);
    chk_eq("b2b_i_rvalid", {31'h0, i_rvalid}, 32'h0);
    step();
    mem_rvalid = 1'b0;

    // Flush while a fetch waits for accept: handshake completes silently.
    i_req = 1'b1; i_addr = 32'h0000_00C0;
    step();
    i_flush = 1'b1;
    sample();
    chk_eq("flr_mem_req", {31'h0, mem_req}, 32'h1);
    chk_eq("flr_gnt_wait", {31'h0, i_gnt}, 32'h0);
    step();
    i_flush = 1'b0; i_req = 1'b0; mem_ready = 1'b1;
    sample();
    chk_eq("flr_mem_req_held", {31'h0, mem_req}, 32'h1);
    chk_eq("flr_gnt_supp", {31'h0, i_gnt}, 32'h0);
    step();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
    sample();
    chk_eq("flr_rvalid_supp", {31'h0, i_rvalid}, 32'h0);
    chk_eq("flr_rdata_zero", i_rdata, 32'h0);
    step();
    mem_rvalid = 1'b0;
    // Fetch request in the same cycle as a flush is ignored in IDLE.
    i_req = 1'b1; i_flush = 1'b1; i_addr = 32'h0000_0048;
    step();
    i_req = 1'b0; i_flush = 1'b0;
    sample();
    chk_eq("idle_flush_ignored", {31'h0, mem_req}, 32'h0);
    step();
    // Drop flag must be gone: a clean fetch delivers its response.
    run_txn(1'b0, 1'b0, 32'h0000_0044, 32'h0, 32'h2222_2222, "post_flush");

    // Contention with zero-wait memory: D,D,D,D,I repeating.
    i_req = 1'b1; i_addr = 32'h0000_1000;
    d_req = 1'b1; d_addr = 32'h0000_2000; d_we = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      exp_i = ((k % 5) == 4);
      mem_ready = 1'b1; mem_rvalid = 1'b0;
      sample();
      chk_eq($sformatf("cont%0d_addr", k), mem_addr, exp_i ? 32'h0000_1000 : 32'h0000_2000);
      chk_eq($sformatf("cont%0d_i_gnt", k), {31'h0, i_gnt}, {31'h0, exp_i});
      chk_eq($sformatf("cont%0d_d_gnt", k), {31'h0, d_gnt}, {31'h0, ~exp_i});
      step();
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0A00 + 32'(k);
      if (k == 9) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      sample();
      chk_eq($sformatf("cont%0d_i_rvalid", k), {31'h0, i_rvalid}, {31'h0, exp_i});
      chk_eq($sformatf("cont%0d_d_rvalid", k), {31'h0, d_rvalid}, {31'h0, ~exp_i});
      step();
    end
    mem_rvalid = 1'b0;
    sample();
    chk_eq("cont_end_idle", {31'h0, mem_req}, 32'h0);
    step();

    // Reset while the port is requesting.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300; d_wdata = 32'h0000_0077;
    step();
    sample();
    chk_eq("rst_pre_mem_req", {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b0; mem_ready = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    d_req = 1'b0; d_we = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_3333;
    #2;
    chk_eq("rst_hold_d_rvalid", {31'h0, d_rvalid}, 32'h0);
    @(negedge clk); #2 rst = 1'b1;
    step();
    sample();
    chk_all_zero("rst_after");
    step();
    mem_rvalid = 1'b0;
    run_txn(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h4444_4444, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
